// File: rtl/axi_lite_if.sv
// AXI-Lite bundle: 32-bit address, 32-bit data, AW/W/B/AR/R channels.
// The master modport drives requests; the slave modport drives responses.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/holy_clint_lite.sv
// holy_clint_lite: minimal RISC-V CLINT behind an AXI-Lite slave port.
// Registers: msip (0x0000), mtimecmp (0x4000/0x4004), mtime (0xBFF8/0xBFFC).
// Optional feature macro CLINT_MTIME_WRITE_EN: makes the mtime halves writable;
// without it, mtime writes are accepted with OKAY and discarded.
module holy_clint_lite #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    axi_lite_if.slave   axi_lite,
    output logic        timer_irq,
    output logic        soft_irq
);

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [2:0] {REG_MSIP, REG_CMP_LO, REG_CMP_HI,
                              REG_TIME_LO, REG_TIME_HI, REG_NONE} reg_sel_e;

    localparam logic [15:0] OFF_MSIP    = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
    localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);

    // Word-granular decode of the 64 KiB window; byte offset bits are ignored.
    function automatic reg_sel_e decode(input logic [15:2] word);
        case (word)
            OFF_MSIP[15:2]:    return REG_MSIP;
            OFF_CMP_LO[15:2]:  return REG_CMP_LO;
            OFF_CMP_HI[15:2]:  return REG_CMP_HI;
            OFF_TIME_LO[15:2]: return REG_TIME_LO;
            OFF_TIME_HI[15:2]: return REG_TIME_HI;
            default:           return REG_NONE;
        endcase
    endfunction

    // Byte-lane merge of write data into an existing 32-bit value.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        return res;
    endfunction

    w_state_e    w_state;
    r_state_e    r_state;
    logic [15:2] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic [15:0] presc;
    logic        tick;

    logic        aw_hs, w_hs, wr_fire;
    logic [15:2] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    reg_sel_e    wr_sel, rd_sel;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    // Upper address bits and byte offsets are intentionally not decoded.
    logic unused_addr;
    assign unused_addr = ^{axi_lite.awaddr[31:16], axi_lite.awaddr[1:0],
                           axi_lite.araddr[31:16], axi_lite.araddr[1:0]};

    assign tick     = (presc == TICK_LAST);
    assign soft_irq = msip;

    // Select the address/data pair of the write that completes this cycle.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        aw_hs   = axi_lite.awvalid && axi_lite.awready;
        w_hs    = axi_lite.wvalid && axi_lite.wready;
        wr_fire = 1'b0;
        wr_addr = axi_lite.awaddr[15:2];
        wr_data = axi_lite.wdata;
        wr_strb = axi_lite.wstrb;
        case (w_state)
            W_IDLE:      wr_fire = aw_hs && w_hs;
            W_HAVE_ADDR: begin
                wr_fire = w_hs;
                wr_addr = aw_addr_q;
            end
            W_HAVE_DATA: begin
                wr_fire = aw_hs;
                wr_data = w_data_q;
                wr_strb = w_strb_q;
            end
            default:     wr_fire = 1'b0;
        endcase
        wr_sel = decode(wr_addr);
    end

    // Read mux, sampled at the AR handshake.
    always_comb begin
        rd_sel  = decode(axi_lite.araddr[15:2]);
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            REG_MSIP:    rd_data = {31'b0, msip};
            REG_CMP_LO:  rd_data = mtimecmp[31:0];
            REG_CMP_HI:  rd_data = mtimecmp[63:32];
            REG_TIME_LO: rd_data = mtime[31:0];
            REG_TIME_HI: rd_data = mtime[63:32];
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    // Write channel FSM with registered ready/response outputs.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state          <= W_IDLE;
            axi_lite.awready <= 1'b1;
            axi_lite.wready  <= 1'b1;
            axi_lite.bvalid  <= 1'b0;
            axi_lite.bresp   <= RESP_OKAY;
            aw_addr_q        <= '0;
            w_data_q         <= '0;
            w_strb_q         <= '0;
        end else begin
            if (wr_fire) begin
                w_state          <= W_RESP;
                axi_lite.awready <= 1'b0;
                axi_lite.wready  <= 1'b0;
                axi_lite.bvalid  <= 1'b1;
                axi_lite.bresp   <= (wr_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                case (w_state)
                    W_IDLE: begin
                        if (aw_hs) begin
                            w_state          <= W_HAVE_ADDR;
                            aw_addr_q        <= axi_lite.awaddr[15:2];
                            axi_lite.awready <= 1'b0;
                        end else if (w_hs) begin
                            w_state         <= W_HAVE_DATA;
                            w_data_q        <= axi_lite.wdata;
                            w_strb_q        <= axi_lite.wstrb;
                            axi_lite.wready <= 1'b0;
                        end
                    end
                    W_RESP: begin
                        if (axi_lite.bready) begin
                            w_state          <= W_IDLE;
                            axi_lite.bvalid  <= 1'b0;
                            axi_lite.awready <= 1'b1;
                            axi_lite.wready  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read channel FSM: capture data at AR handshake, hold until R handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= R_IDLE;
            axi_lite.arready <= 1'b1;
            axi_lite.rvalid  <= 1'b0;
            axi_lite.rdata   <= '0;
            axi_lite.rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi_lite.arvalid) begin
                        r_state          <= R_DATA;
                        axi_lite.arready <= 1'b0;
                        axi_lite.rvalid  <= 1'b1;
                        axi_lite.rdata   <= rd_data;
                        axi_lite.rresp   <= rd_resp;
                    end
                end
                default: begin
                    if (axi_lite.rready) begin
                        r_state          <= R_IDLE;
                        axi_lite.rvalid  <= 1'b0;
                        axi_lite.arready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Timer, compare and software-interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip      <= 1'b0;
            mtimecmp  <= '1;
            mtime     <= '0;
            presc     <= '0;
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= (mtime >= mtimecmp);
            presc     <= tick ? 16'd0 : presc + 16'd1;
            if (tick) mtime <= mtime + 64'd1;
            // NOTE: a later non-blocking assignment overrides the tick above, so a software write wins.
            if (wr_fire) begin
                case (wr_sel)
                    REG_MSIP:   if (wr_strb[0]) msip <= wr_data[0];
                    REG_CMP_LO: mtimecmp[31:0]  <= merge(mtimecmp[31:0], wr_data, wr_strb);
                    REG_CMP_HI: mtimecmp[63:32] <= merge(mtimecmp[63:32], wr_data, wr_strb);
`ifdef CLINT_MTIME_WRITE_EN
                    REG_TIME_LO: if (|wr_strb)
                        mtime <= {mtime[63:32], merge(mtime[31:0], wr_data, wr_strb)};
                    REG_TIME_HI: if (|wr_strb)
                        mtime <= {merge(mtime[63:32], wr_data, wr_strb), mtime[31:0]};
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/holy_clint_lite.md
# holy_clint_lite

AXI-Lite slave implementing a minimal RISC-V CLINT: a 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and an `msip` software-interrupt bit. It sits downstream of the core's uncached data path, behind the SoC AXI-Lite interconnect. It turns the core's MMIO loads and stores into register accesses. Its outputs drive the core's machine timer and software interrupt lines.

## Interface
Parameters:
- `TICK_DIV`, default 1: `clk` cycles per `mtime` increment. Legal range is ≥1, and the prescaler is 16 bits wide.

Ports:
- `clk`  in  1  core/AXI clock. The block has one clock domain only.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `axi_lite`  `axi_lite_if.slave`  —  32-bit address, 32-bit data AXI-Lite slave port (AW, W, B, AR, R channels).
- `timer_irq`  out  1  high while `mtime >= mtimecmp`.
- `soft_irq`  out  1  equal to `msip[0]`.

## Operation
- Address decode uses `awaddr/araddr[15:0]`. Bits [1:0] are ignored and upper bits are not decoded.
- Register map:
  - 0x0000 `msip`: only bit 0 is writable; all other bits read 0.
  - 0x4000 `mtimecmp[31:0]`.
  - 0x4004 `mtimecmp[63:32]`.
  - 0xBFF8 `mtime[31:0]`.
  - 0xBFFC `mtime[63:32]`.
- Unmapped offsets:
  - Writes are dropped and return `bresp=2'b10` (SLVERR).
  - Reads return `rdata=0` with `rresp=2'b10`.
  - Mapped accesses return OKAY (2'b00).
- `wstrb` masks each byte lane on writes. `wstrb=0` is a legal no-op and returns OKAY.
- Write FSM states:
  - W_IDLE: AW and W can each be accepted, in either order or in the same cycle.
  - W_HAVE_ADDR: holding the address, waiting for W.
  - W_HAVE_DATA: holding the data, waiting for AW.
  - W_RESP: `bvalid` asserted until `bready`, then back to W_IDLE.
  - From W_IDLE, AW and W handshaking in the same cycle go directly to W_RESP.
- Read FSM states:
  - R_IDLE: `arready=1`.
  - R_DATA: `rvalid=1` with data latched at the AR handshake, held until `rready`, then back to R_IDLE.
- `mtime` counter:
  - A prescaler counts 0..TICK_DIV-1.
  - On wrap, `mtime` increments by 1 as a full 64-bit add, so the low half carries into the high half.
  - When TICK_DIV=1, `mtime` increments every cycle.
- `timer_irq` is registered: an unsigned 64-bit compare of `mtime` and `mtimecmp` from the previous cycle.

## Timing
- Reset values:
  - `mtime` = 0, prescaler = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `msip` = 0.
  - `timer_irq` = 0, `soft_irq` = 0.
  - `awready`, `wready` and `arready` = 1.
  - `bvalid` and `rvalid` = 0; `bresp`, `rresp` and `rdata` = 0.
- Ready signals:
  - `awready` is 1 only in W_IDLE and W_HAVE_DATA.
  - `wready` is 1 only in W_IDLE and W_HAVE_ADDR.
- Write latency:
  - The register update takes effect on the clock edge where the second of AW/W handshakes.
  - `bvalid` goes high in the following cycle.
  - Minimum write time is 2 cycles from AW, W to B.
  - This accommodates the core's sequential AW-then-W master.
- Read latency: `rvalid` goes high the cycle after the AR handshake, and `rdata` is stable while `rvalid && !rready`.
- Simultaneous read and write to the same register: the read returns the value from before the write.
- A software write to `mtime` in the same cycle as a tick increment: the write wins.
  - The written half takes the written bytes.
  - The other half keeps its pre-increment value, and no carry is applied.
- The new `mtimecmp` or `mtime` value is reflected in `timer_irq` one cycle after the register update.
- `soft_irq` follows `msip` with zero added delay, since it is a register output.
- Reset asserted mid-transaction:
  - All state returns to reset values immediately (asynchronous).
  - Pending B and R responses are discarded.
- Wrap-around: `mtime` rolls over from 64'hFFFF_FFFF_FFFF_FFFF to 0, and `timer_irq` follows the compare with no special handling.

## Configuration
- `CLINT_MTIME_WRITE_EN`, when defined: `mtime` halves are writable as described above.
- When not defined: writes to 0xBFF8 and 0xBFFC are ignored but still return OKAY. `mtime` is then only ever changed by reset and ticks.

## Test plan
- Reset, then read 0x4004 → `rdata=32'hFFFF_FFFF`, `rresp=0`, `timer_irq=0`. Read 0x0000 → 0.
- Send AW for 0x0000, then W one cycle later with `wdata=1`, `wstrb=4'hF` → `bvalid` the cycle after W, `bresp=0`, `soft_irq=1`. Write 0 → `soft_irq=0`.
- TICK_DIV=1: write `mtimecmp` hi=0, then lo=20 → `timer_irq` rises on the cycle after `mtime` reaches 20 and stays high.
- With `CLINT_MTIME_WRITE_EN`: write 0xBFF8=32'hFFFF_FFFE and 0xBFFC=0, wait 2 ticks → `mtime` = 64'h1_0000_0000, so the carry is verified. Without the macro, the same writes return OKAY and `mtime` is unchanged.
- Read 0x1234 → `rresp=2'b10`, `rdata=0`. Write 0x1234 → `bresp=2'b10`, and no register changes.
- Hold `rready`/`bready` low for 5 cycles → `rvalid`/`bvalid` and data stay stable, and `arready`/`awready` stay low.
- Assert `rst_n` low mid-read → `rvalid` drops immediately.
